// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU run sequencer: FSM state encoding and error codes.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_RELEASE   = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_START     = 3'd4,
        ST_START_LO  = 3'd5,
        ST_RUN       = 3'd6,
        ST_FINISH    = 3'd7
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_LOAD_OVF = 2'b01;
    localparam logic [1:0] ERR_DONE_TMO = 2'b10;
    localparam logic [1:0] ERR_NO_START = 2'b11;

    // States in which the CPU must be held in reset.
    function automatic logic cpu_held(input state_t s);
        return (s == ST_IDLE) || (s == ST_LOAD) || (s == ST_FINISH);
    endfunction

endpackage

// File: rtl/seq_load_ctr.sv
// Instruction-memory load address counter; saturates at the top address
// instead of wrapping, and flags when it sits there.
module seq_load_ctr #(
    parameter int ADDR_W = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr,
    output logic              at_max
);

    assign at_max = &addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr <= '0;
        end else if (clr) begin
            addr <= '0;
        end else if (inc && !at_max) begin
            addr <= addr + ADDR_W'(1);
        end
    end

endmodule

// File: rtl/cpu_run_sequencer.sv
// Host-side sequencer: streams a program into instruction memory with the CPU in
// reset, then releases it, issues start and runs it for a host-set cycle budget.
module cpu_run_sequencer
    import cpu_seq_pkg::*;
#(
    parameter int WORD_W     = 8,
    parameter int ADDR_W     = 13,
    parameter int CYC_W      = 16,
    parameter int START_HOLD = 2,
    parameter int DONE_TMO   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_go,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [WORD_W-1:0] ld_data,
    input  logic              ld_last,
    input  logic              run_req,
    input  logic [CYC_W-1:0]  run_cycles,
    input  logic              abort,
    output logic              busy,
    output logic              run_done,
    output logic              err,
    output logic [1:0]        err_code,
    output logic [CYC_W-1:0]  cycles_used,
    output logic              cpu_rst,
    output logic              cpu_start,
    input  logic              cpu_done,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic [2:0]        dbg_state
);

    localparam logic [CYC_W-1:0] TMO_LAST  = CYC_W'(DONE_TMO - 1);
    localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(START_HOLD - 1);
    localparam logic [CYC_W-1:0] CYC_ONE   = CYC_W'(1);

    state_t            state, next_state;
    logic [CYC_W-1:0]  cnt;
    logic [CYC_W-1:0]  budget;
    logic [ADDR_W-1:0] ld_addr;
    logic              at_max;
    logic              beat;
    logic              ctr_clr;
    logic              clr_err;
    logic              set_err;
    logic [1:0]        new_code;
    logic              fin_ok;

    // Load handshake: a beat transfers on a cycle where ld_valid and ld_ready are
    // both high; ld_ready is high exactly while in LOAD. Abort suppresses the beat.
    assign beat      = (state == ST_LOAD) && ld_valid && !abort;
    assign dbg_state = state;

    seq_load_ctr #(.ADDR_W(ADDR_W)) u_ctr (
        .clk    (clk),
        .rst    (rst),
        .clr    (ctr_clr),
        .inc    (beat),
        .addr   (ld_addr),
        .at_max (at_max)
    );

    always_comb begin
        next_state = state;
        ctr_clr    = 1'b0;
        clr_err    = 1'b0;
        set_err    = 1'b0;
        new_code   = ERR_NONE;
        fin_ok     = 1'b0;
        if (abort) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_go) begin
                        next_state = ST_LOAD;
                        ctr_clr    = 1'b1;
                        clr_err    = 1'b1;
                    end else if (run_req) begin
                        clr_err = 1'b1;
                        if (run_cycles == '0) begin
                            next_state = ST_FINISH;
                            fin_ok     = 1'b1;
                        end else begin
                            next_state = ST_RELEASE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (ld_valid) begin
                        if (ld_last) begin
                            next_state = ST_IDLE;
                        end else if (at_max) begin
                            next_state = ST_IDLE;
                            set_err    = 1'b1;
                            new_code   = ERR_LOAD_OVF;
                        end
                    end
                end
                ST_RELEASE: next_state = ST_WAIT_DONE;
                ST_WAIT_DONE: begin
                    if (cpu_done) begin
                        next_state = ST_START;
                    end else if (cnt == TMO_LAST) begin
                        next_state = ST_FINISH;
                        set_err    = 1'b1;
                        new_code   = ERR_DONE_TMO;
                    end
                end
                ST_START: begin
                    if (cnt == HOLD_LAST) next_state = ST_START_LO;
                end
                ST_START_LO: begin
                    // Still idle after start fell means the controller never took it.
                    if (cpu_done) begin
                        next_state = ST_FINISH;
                        set_err    = 1'b1;
                        new_code   = ERR_NO_START;
                    end else begin
                        next_state = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (cnt == budget - CYC_ONE) begin
                        next_state = ST_FINISH;
                        fin_ok     = 1'b1;
                    end
                end
                ST_FINISH: next_state = ST_IDLE;
                default:   next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            budget      <= '0;
            cpu_rst     <= 1'b1;
            cpu_start   <= 1'b0;
            ld_ready    <= 1'b0;
            busy        <= 1'b0;
            run_done    <= 1'b0;
            err         <= 1'b0;
            err_code    <= ERR_NONE;
            cycles_used <= '0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            state     <= next_state;
            // cnt measures time spent in the current state.
            cnt       <= (next_state != state) ? '0 : cnt + CYC_ONE;
            cpu_rst   <= cpu_held(next_state);
            cpu_start <= (next_state == ST_START);
            ld_ready  <= (next_state == ST_LOAD);
            busy      <= (next_state != ST_IDLE);
            run_done  <= fin_ok;
            mem_we    <= beat;
            if (state == ST_IDLE && run_req && !load_go && !abort) begin
                budget <= run_cycles;
            end
            if (clr_err) begin
                err      <= 1'b0;
                err_code <= ERR_NONE;
            end
            if (set_err) begin
                err      <= 1'b1;
                err_code <= new_code;
            end
            if (fin_ok) begin
                cycles_used <= (state == ST_RUN) ? budget : '0;
            end
            if (beat) begin
                mem_addr  <= ld_addr;
                mem_wdata <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Bench for cpu_run_sequencer: IDLE decision table, hand-written load/run/error/abort
// sequences, and randomized loads and runs checked against phase-duration arithmetic.
module tb_cpu_run_sequencer;
  localparam int WORD_W     = 8;
  localparam int ADDR_W     = 3;
  localparam int CYC_W      = 16;
  localparam int START_HOLD = 2;
  localparam int DONE_TMO   = 4;
  localparam int DEPTH      = 1 << ADDR_W;
  localparam int W          = ADDR_W + WORD_W;

  logic clk = 1'b0;
  logic rst;
  logic load_go, ld_valid, ld_ready, ld_last, run_req, abort;
  logic [WORD_W-1:0] ld_data;
  logic [CYC_W-1:0] run_cycles, cycles_used;
  logic busy, run_done, err, cpu_rst, cpu_start, cpu_done, mem_we;
  logic [1:0] err_code;
  logic [ADDR_W-1:0] mem_addr;
  logic [WORD_W-1:0] mem_wdata;
  logic [2:0] dbg_state;

  int tests = 0;
  int fails = 0;
  int done_pulses = 0;
  int last_used = 0;
  int cpu_mode = 0;  // 0 model CPU, 1 done stuck at 0, 2 done stuck at 1
  logic m_done;
  logic [W-1:0] exp_q[$];
  logic [WORD_W-1:0] beats[16];

  typedef struct {
    logic             load_go;
    logic             run_req;
    logic             abort;
    logic             ld_valid;
    logic [CYC_W-1:0] cyc;
    logic             e_busy;
    logic             e_ready;
    logic             e_cpu_rst;
    logic             e_run_done;
    logic             e_mem_we;
  } vec_t;
  vec_t vecs[8];

  cpu_run_sequencer #(
    .WORD_W(WORD_W), .ADDR_W(ADDR_W), .CYC_W(CYC_W),
    .START_HOLD(START_HOLD), .DONE_TMO(DONE_TMO)
  ) dut (
    .clk(clk), .rst(rst), .load_go(load_go), .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_data(ld_data), .ld_last(ld_last), .run_req(run_req), .run_cycles(run_cycles),
    .abort(abort), .busy(busy), .run_done(run_done), .err(err), .err_code(err_code),
    .cycles_used(cycles_used), .cpu_rst(cpu_rst), .cpu_start(cpu_start),
    .cpu_done(cpu_done), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .dbg_state(dbg_state)
  );

  // clock / CPU model: idle (done=1) while in reset, leaves idle once it samples start
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (cpu_rst) m_done <= 1'b1;
    else if (cpu_start) m_done <= 1'b0;
  end

  assign cpu_done = (cpu_mode == 0) ? m_done : (cpu_mode == 2);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic [W-1:0] e;
    @(posedge clk);
    #1;
    if (run_done) done_pulses++;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mem_write_unexpected: got addr %0h data %0h expected no write", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        check("mem_write", 32'({mem_addr, mem_wdata}), 32'(e));
      end
    end
  endtask

  task automatic clear_inputs();
    load_go = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    run_req = 0; run_cycles = '0; abort = 0;
  endtask

  // Streams n beats from beats[]; with use_last the last beat carries ld_last,
  // otherwise the stream runs past the top address.
  task automatic do_load(input int n, input logic use_last, input int gap_pct);
    int nw, i, guard;
    logic acc;
    nw = use_last ? n : DEPTH;
    for (int k = 0; k < nw; k++) exp_q.push_back({ADDR_W'(k), beats[k]});
    load_go = 1;
    tick();
    load_go = 0;
    check("load_entry_ready", ld_ready, 1);
    i = 0;
    guard = 0;
    while (busy && guard < 300) begin
      ld_valid = ($urandom_range(0, 99) >= gap_pct) && (i < n);
      ld_data  = beats[i % 16];
      ld_last  = use_last && (i == n - 1);
      acc = ld_valid && ld_ready;
      tick();
      guard++;
      if (acc) i++;
    end
    ld_valid = 0;
    ld_last = 0;
    if (guard >= 300) begin
      tests++;
      fails++;
      $display("FAIL load_timeout: got %0d cycles expected return to idle", guard);
    end
    if (gap_pct == 0) check("load_cycles", guard, nw);
    check("load_beats_accepted", i, nw);
    check("load_ready_after", ld_ready, 0);
    check("load_err", err, !use_last);
    check("load_err_code", err_code, use_last ? 0 : 1);
    check("load_cpu_rst", cpu_rst, 1);
    // a beat offered in IDLE is not taken
    ld_valid = 1;
    ld_data = 8'hee;
    tick();
    tick();
    ld_valid = 0;
    check("load_ready_idle", ld_ready, 0);
    check("load_queue_drained", exp_q.size(), 0);
  endtask

  // Expected timing comes from phase durations: the request edge, RELEASE 1,
  // WAIT_DONE 1 (done present) or DONE_TMO, START START_HOLD, START_LO 1, RUN b.
  task automatic do_run(input int b, input int mode);
    int k, done_at, err_at, starts, err_k1, exp_done, exp_err, exp_starts, exp_end;
    logic released;
    cpu_mode = mode;
    done_pulses = 0;
    run_req = 1;
    run_cycles = CYC_W'(b);
    k = 0; done_at = -1; err_at = -1; starts = 0; released = 0; err_k1 = -1;
    do begin
      tick();
      k++;
      if (k == 1) begin
        run_req = 0;
        run_cycles = CYC_W'($urandom_range(1, 60000));
        err_k1 = err;
      end
      if (run_done && done_at < 0) done_at = k;
      if (err && err_at < 0) err_at = k;
      if (cpu_start) starts++;
      if (!cpu_rst) released = 1;
    end while (busy && k < b + 60);
    exp_done = -1; exp_err = -1; exp_starts = START_HOLD;
    if (mode == 0 && b == 0) begin
      exp_done = 1; exp_starts = 0;
    end else if (mode == 0) begin
      exp_done = 1 + 1 + 1 + START_HOLD + 1 + b;
    end else if (mode == 1) begin
      exp_err = 1 + 1 + DONE_TMO; exp_starts = 0;
    end else begin
      exp_err = 1 + 1 + 1 + START_HOLD + 1;
    end
    exp_end = ((mode == 0) ? exp_done : exp_err) + 1;
    check("run_clears_err", err_k1, 0);
    check("run_done_cycle", done_at, exp_done);
    check("run_done_pulses", done_pulses, (mode == 0) ? 1 : 0);
    check("run_err_cycle", err_at, exp_err);
    check("run_err_code", err_code, (mode == 0) ? 0 : (mode == 1) ? 2 : 3);
    check("run_start_cycles", starts, exp_starts);
    check("run_released", released, !(mode == 0 && b == 0));
    check("run_end_cycle", k, exp_end);
    check("run_end_rst", cpu_rst, 1);
    if (mode == 0) begin
      last_used = b;
      check("run_cycles_used", cycles_used, b);
    end
    cpu_mode = 0;
  endtask

  initial begin
    clear_inputs();
    // reset
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_cpu_rst", cpu_rst, 1);
    check("rst_outputs", {busy, run_done, err, err_code, ld_ready, cpu_start, mem_we}, 0);
    check("rst_mem_bus", {mem_addr, mem_wdata}, 0);
    check("rst_cycles_used", cycles_used, 0);
    rst = 0;
    @(negedge clk);

    // IDLE decision table: one request cycle, check, then abort back to IDLE
    vecs[0] = '{0, 0, 0, 0, 16'd0, 0, 0, 1, 0, 0};
    vecs[1] = '{1, 0, 0, 0, 16'd0, 1, 1, 1, 0, 0};
    vecs[2] = '{0, 1, 0, 0, 16'd5, 1, 0, 0, 0, 0};
    vecs[3] = '{1, 1, 0, 0, 16'd5, 1, 1, 1, 0, 0};
    vecs[4] = '{0, 1, 0, 0, 16'd0, 1, 0, 1, 1, 0};
    vecs[5] = '{1, 0, 1, 0, 16'd0, 0, 0, 1, 0, 0};
    vecs[6] = '{0, 1, 1, 0, 16'd7, 0, 0, 1, 0, 0};
    vecs[7] = '{0, 0, 0, 1, 16'd0, 0, 0, 1, 0, 0};
    for (int i = 0; i < 8; i++) begin
      load_go = vecs[i].load_go; run_req = vecs[i].run_req; abort = vecs[i].abort;
      ld_valid = vecs[i].ld_valid; run_cycles = vecs[i].cyc; ld_data = 8'h5a;
      tick();
      clear_inputs();
      check($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
      check($sformatf("vec%0d_ld_ready", i), ld_ready, vecs[i].e_ready);
      check($sformatf("vec%0d_cpu_rst", i), cpu_rst, vecs[i].e_cpu_rst);
      check($sformatf("vec%0d_run_done", i), run_done, vecs[i].e_run_done);
      check($sformatf("vec%0d_mem_we", i), mem_we, vecs[i].e_mem_we);
      abort = 1;
      tick();
      abort = 0;
      check($sformatf("vec%0d_return_idle", i), busy, 0);
    end
    check("zero_budget_cycles_used", cycles_used, 0);

    // 5-beat program, then a 10-cycle run
    for (int k = 0; k < 16; k++) beats[k] = WORD_W'(8'h11 * (k + 1));
    do_load(5, 1'b1, 0);
    do_run(10, 0);

    // overflow: 9 beats without ld_last into an 8-word memory
    for (int k = 0; k < 16; k++) beats[k] = WORD_W'($urandom_range(0, 255));
    do_load(9, 1'b0, 0);

    // done timeout, then start not taken
    do_run(5, 1);
    do_run(5, 2);
    load_go = 1;
    tick();
    load_go = 0;
    check("load_go_clears_err", {err, err_code}, 0);
    abort = 1;
    tick();
    abort = 0;

    // abort in the middle of RUN
    done_pulses = 0;
    run_req = 1;
    run_cycles = 16'd50;
    tick();
    run_req = 0;
    for (int k = 0; k < 14; k++) tick();
    check("abort_run_in_progress", {busy, cpu_rst}, 2'b10);
    abort = 1;
    tick();
    abort = 0;
    check("abort_run_idle", {busy, cpu_rst, cpu_start}, 3'b010);
    for (int k = 0; k < 60; k++) tick();
    check("abort_run_no_done", done_pulses, 0);
    check("abort_run_cycles_held", cycles_used, last_used);

    // abort in the middle of LOAD: three words stay written, the abort beat does not
    for (int k = 0; k < 3; k++) exp_q.push_back({ADDR_W'(k), beats[k]});
    load_go = 1;
    tick();
    load_go = 0;
    for (int k = 0; k < 3; k++) begin
      ld_valid = 1;
      ld_data = beats[k];
      tick();
    end
    ld_data = 8'hc3;
    abort = 1;
    tick();
    abort = 0;
    ld_valid = 0;
    check("abort_load_idle", {busy, ld_ready, cpu_rst}, 3'b001);
    check("abort_load_no_write", mem_we, 0);
    tick();
    check("abort_load_queue", exp_q.size(), 0);

    // randomized loads and runs
    for (int r = 0; r < 14; r++) begin
      int op, n, b;
      logic ul;
      op = $urandom_range(0, 2);
      if (op == 0) begin
        n = $urandom_range(1, 10);
        ul = (n < DEPTH) ? 1'b1 : (n == DEPTH) ? 1'($urandom_range(0, 1)) : 1'b0;
        for (int k = 0; k < 16; k++) beats[k] = WORD_W'($urandom_range(0, 255));
        do_load(n, ul, 30);
      end else if (op == 1) begin
        b = $urandom_range(0, 30);
        do_run(b, 0);
      end else begin
        b = $urandom_range(1, 20);
        do_run(b, $urandom_range(1, 2));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
